// File: rtl/fc_pkg.sv
// Shared types for the fully connected layer front end: skewer FSM states and
// the per-stage record carried down each skew lane.
package fc_pkg;

    // Widest element any lane can carry; lanes use the low BitSize bits.
    localparam int FC_DATA_MAX = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } skew_state_t;

    typedef struct packed {
        logic [FC_DATA_MAX-1:0] data;
        logic                   valid;
        logic                   start;
        logic                   last;
    } lane_stage_t;

endpackage

// File: rtl/fc_input_skewer_if.sv
// Row-in / skewed-slice-out bundle between the row source, the skewer and fc_layer.
interface fc_input_skewer_if #(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 2
);
    import fc_pkg::*;

    logic                                  in_valid;
    logic                                  in_start;
    logic                                  in_last;
    logic [NumOfInputs-1:0][BitSize-1:0]   in_data;
    logic                                  in_ready;
    logic                                  out_valid;
    logic                                  out_start;
    logic                                  out_done;
    logic [NumOfInputs-1:0][BitSize-1:0]   out_data;

    modport master (
        output in_valid, in_start, in_last, in_data,
        input  in_ready, out_valid, out_start, out_done, out_data
    );

    modport slave (
        input  in_valid, in_start, in_last, in_data,
        output in_ready, out_valid, out_start, out_done, out_data
    );

endinterface

// File: rtl/fc_input_skewer_lane.sv
// skew_lane: Depth-stage delay line of lane records that shifts only when adv is high.
module skew_lane
    import fc_pkg::*;
#(
    parameter int BitSize = 8,
    parameter int Depth   = 1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic               adv,
    input  logic [BitSize-1:0] din_data,
    input  logic               din_valid,
    input  logic               din_start,
    input  logic               din_last,
    output lane_stage_t        dout
);

    lane_stage_t stage_p [Depth];

    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int k = 0; k < Depth; k++) begin
                stage_p[k] <= '0;
            end
        end else if (adv) begin
            stage_p[0] <= '{data:  FC_DATA_MAX'(din_data),
                            valid: din_valid,
                            start: din_start,
                            last:  din_last};
            for (int k = 1; k < Depth; k++) begin
                stage_p[k] <= stage_p[k-1];
            end
        end
    end

    assign dout = stage_p[Depth-1];

endmodule

// File: rtl/fc_input_skewer.sv
// fc_input_skewer: turns parallel rows into the diagonal stream fc_layer expects,
// padding the ramp-in with dead lanes and flushing the ramp-out on its own.
module fc_input_skewer
    import fc_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfInputs = 2
) (
    input  logic          clk,
    input  logic          res_n,
    fc_input_skewer_if.slave bus
);

    localparam int                CNT_W     = $clog2(NumOfInputs) + 1;
    localparam logic [CNT_W-1:0]  FLUSH_LEN = CNT_W'(NumOfInputs - 1);

    skew_state_t                          state;
    logic [CNT_W-1:0]                     flush_cnt;
    logic                                 adv_p1;
    logic                                 accept;
    logic                                 adv;
    lane_stage_t                          lane_out [NumOfInputs];
    logic [NumOfInputs-1:0]               lane_vld;
    logic [NumOfInputs-1:0][BitSize-1:0]  odata;

    assign bus.in_ready = (state != FLUSH);
    // Outside RUN only a start row opens a matrix; anything else is dropped.
    assign accept = bus.in_valid & bus.in_ready & ((state == RUN) | bus.in_start);
    assign adv    = accept | (state == FLUSH);

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
            adv_p1    <= 1'b0;
        end else begin
            adv_p1 <= adv;
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (bus.in_last) begin
                            if (NumOfInputs == 1) begin
                                state <= IDLE;
                            end else begin
                                state     <= FLUSH;
                                flush_cnt <= FLUSH_LEN;
                            end
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt <= CNT_W'(1)) begin
                        state     <= IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

    // Lane i is i+1 deep, which produces the one-cycle-per-lane skew.
    for (genvar i = 0; i < NumOfInputs; i++) begin : g_lane
        skew_lane #(
            .BitSize (BitSize),
            .Depth   (i + 1)
        ) u_lane (
            .clk       (clk),
            .res_n     (res_n),
            .adv       (adv),
            .din_data  (accept ? bus.in_data[i] : '0),
            .din_valid (accept),
            .din_start (accept & bus.in_start),
            .din_last  (accept & bus.in_last),
            .dout      (lane_out[i])
        );

        assign lane_vld[i] = lane_out[i].valid;
        assign odata[i]    = lane_out[i].valid ? lane_out[i].data[BitSize-1:0] : '0;
    end

    // Stages hold on a stalled cycle, so the flags are qualified by the last advance.
    assign bus.out_data  = odata;
    assign bus.out_valid = adv_p1 & (|lane_vld);
    assign bus.out_start = adv_p1 & lane_out[0].valid & lane_out[0].start;
    assign bus.out_done  = adv_p1 & lane_out[NumOfInputs-1].valid & lane_out[NumOfInputs-1].last;

endmodule

// File: tb/tb_fc_input_skewer.sv
// Directed bench for fc_input_skewer with a 4-lane and a 1-lane instance.
module tb_fc_input_skewer;

    logic clk = 1'b0;
    logic res_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fc_input_skewer_if #(.BitSize(8), .NumOfInputs(4)) if4 ();
    fc_input_skewer_if #(.BitSize(8), .NumOfInputs(1)) if1 ();

    fc_input_skewer #(.BitSize(8), .NumOfInputs(4)) dut4 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (if4)
    );

    fc_input_skewer #(.BitSize(8), .NumOfInputs(1)) dut1 (
        .clk   (clk),
        .res_n (res_n),
        .bus   (if1)
    );

    // Packed as {lane3,lane2,lane1,lane0}
    logic [31:0] rows [4] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
    logic [31:0] diag [7] = '{32'h00000000, 32'h00000110, 32'h00021120, 32'h03122130,
                              32'h13223100, 32'h23320000, 32'h33000000};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic s, input logic l, input logic [31:0] d);
        if4.in_valid = v;
        if4.in_start = s;
        if4.in_last  = l;
        if4.in_data  = d;
    endtask

    task automatic drive1(input logic v, input logic s, input logic l, input logic [7:0] d);
        if1.in_valid = v;
        if1.in_start = s;
        if1.in_last  = l;
        if1.in_data  = d;
    endtask

    task automatic test_reset();
        res_n = 1'b0;
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        drive1(1'b0, 1'b0, 1'b0, 8'h0);
        tick();
        tick();
        total++;
        if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_flags4: got %b want 0001",
                     {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready});
        end
        total++;
        if (if4.out_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_data4: got %h want 00000000", if4.out_data);
        end
        total++;
        if ({if1.out_valid, if1.out_start, if1.out_done, if1.in_ready, if1.out_data} !== 12'h100) begin
            bad++;
            $display("FAIL reset_n1: got %h want 100",
                     {if1.out_valid, if1.out_start, if1.out_done, if1.in_ready, if1.out_data});
        end
        res_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] ef;
        logic [31:0] ed;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) drive4(1'b1, k == 0, k == 3, rows[k]);
            else       drive4(1'b1, 1'b0, 1'b0, 32'hEEEEEEEE);
            tick();
            if (k < 7) begin
                ef = {1'b1, k == 0, k == 6, !(k >= 3 && k <= 5)};
                ed = diag[k];
            end else begin
                ef = 4'b0001;
                ed = 32'h33000000;
            end
            total++;
            if (if4.out_data !== ed) begin
                bad++;
                $display("FAIL b2b_data cyc%0d: got %h want %h", k, if4.out_data, ed);
            end
            total++;
            if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready} !== ef) begin
                bad++;
                $display("FAIL b2b_flags cyc%0d: got %b want %b", k,
                         {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready}, ef);
            end
        end
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_single();
        logic [31:0] sd [5] = '{32'h000000A1, 32'h0000B200, 32'h00C30000, 32'hD4000000, 32'hD4000000};
        logic [3:0]  sf [5] = '{4'b1100, 4'b1000, 4'b1000, 4'b1011, 4'b0001};
        drive4(1'b1, 1'b1, 1'b1, 32'hD4C3B2A1);
        for (int k = 0; k < 5; k++) begin
            tick();
            drive4(1'b0, 1'b0, 1'b0, 32'h0);
            total++;
            if (if4.out_data !== sd[k]) begin
                bad++;
                $display("FAIL single_data cyc%0d: got %h want %h", k, if4.out_data, sd[k]);
            end
            total++;
            if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready} !== sf[k]) begin
                bad++;
                $display("FAIL single_flags cyc%0d: got %b want %b", k,
                         {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready}, sf[k]);
            end
        end
    endtask

    task automatic test_gap();
        int          gi [9] = '{0, 1, 1, 1, 2, 3, 4, 5, 6};
        logic [3:0]  ef;
        logic [31:0] ed;
        for (int k = 0; k < 10; k++) begin
            case (k)
                0:       drive4(1'b1, 1'b1, 1'b0, rows[0]);
                1:       drive4(1'b1, 1'b0, 1'b0, rows[1]);
                4:       drive4(1'b1, 1'b0, 1'b0, rows[2]);
                5:       drive4(1'b1, 1'b0, 1'b1, rows[3]);
                default: drive4(1'b0, 1'b0, 1'b0, 32'h0);
            endcase
            tick();
            if (k < 9) begin
                ef = {!(k == 2 || k == 3), k == 0, k == 8, !(k >= 5 && k <= 7)};
                ed = diag[gi[k]];
            end else begin
                ef = 4'b0001;
                ed = 32'h33000000;
            end
            total++;
            if (if4.out_data !== ed) begin
                bad++;
                $display("FAIL gap_data cyc%0d: got %h want %h", k, if4.out_data, ed);
            end
            total++;
            if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready} !== ef) begin
                bad++;
                $display("FAIL gap_flags cyc%0d: got %b want %b", k,
                         {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready}, ef);
            end
        end
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, k == 0, k == 3, rows[k]);
            tick();
        end
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
        total++;
        if (if4.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL frst_in_flush: got in_ready=%b want 0", if4.in_ready);
        end
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        total++;
        if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data} !== 36'h1_00000000) begin
            bad++;
            $display("FAIL frst_clear: got %h want 100000000",
                     {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data});
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data} !== 36'h1_00000000) begin
                bad++;
                $display("FAIL frst_quiet cyc%0d: got %h want 100000000", k,
                         {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data});
            end
        end
    endtask

    task automatic test_idle_drop();
        drive4(1'b1, 1'b0, 1'b0, 32'hFFFFFFFF);
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data} !== 36'h1_33000000) begin
                bad++;
                $display("FAIL drop cyc%0d: got %h want 133000000", k,
                         {if4.out_valid, if4.out_start, if4.out_done, if4.in_ready, if4.out_data});
            end
        end
        drive4(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_n1();
        logic [7:0] nd [4] = '{8'h05, 8'h06, 8'h07, 8'h07};
        logic [3:0] nf [4] = '{4'b1101, 4'b1001, 4'b1011, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            if (k < 3) drive1(1'b1, k == 0, k == 2, nd[k]);
            else       drive1(1'b0, 1'b0, 1'b0, 8'h0);
            tick();
            total++;
            if (if1.out_data !== nd[k]) begin
                bad++;
                $display("FAIL n1_data cyc%0d: got %h want %h", k, if1.out_data, nd[k]);
            end
            total++;
            if ({if1.out_valid, if1.out_start, if1.out_done, if1.in_ready} !== nf[k]) begin
                bad++;
                $display("FAIL n1_flags cyc%0d: got %b want %b", k,
                         {if1.out_valid, if1.out_start, if1.out_done, if1.in_ready}, nf[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_gap();
        test_flush_reset();
        test_back_to_back();
        test_idle_drop();
        test_single();
        test_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
